ppu_vram_port: RTL and testbench
================================

// Module: ppu_vram_port
// PURPOSE
// - CPU-side PPUADDR/PPUDATA engine for the PPU: owns the CPU VRAM address, the w toggle,
//   the PPUDATA read buffer and a posted op queue to VRAM.
// - Queued ops drain only in render-idle slots (mem_gnt); palette space ($3F00+) bypasses the queue.
// - Sits between the ppu top-level register decode and the VRAM/CHR arbiter.
// PARAMETERS
// - ADDR_W   14  VRAM address width
// - DATA_W   8   data width
// - Q_DEPTH  4   posted-op queue depth (power of 2, >=2)
// - RD_LAT   1   cycles from mem_gnt to valid mem_rdata (>=1)
// - PAL_HI   6'h3F  addr[13:8] value selecting palette space
// PORTS
// - clk        in   1        clock
// - rst        in   1        sync reset, active-high
// - reg_we     in   1        1-cycle CPU write strobe (edge-detected by parent)
// - reg_re     in   1        1-cycle CPU read strobe
// - reg_sel    in   3        register index: 5 = SCROLL, 6 = ADDR, 7 = DATA
// - reg_wdata  in   DATA_W   CPU write data
// - reg_rdata  out  DATA_W   PPUDATA read result; valid the cycle after reg_re, then held
// - inc32      in   1        ppuctrl[2]: address step 32, else 1
// - w_clr      in   1        PPUSTATUS read: clear w
// - w_o        out  1        current write toggle (parent uses it for SCROLL byte select)
// - vaddr_o    out  ADDR_W   current CPU VRAM address
// - mem_req    out  1        queue head op pending
// - mem_gnt    in   1        arbiter accepts head op this cycle
// - mem_we     out  1        head op is a write
// - mem_addr   out  ADDR_W   head op address
// - mem_wdata  out  DATA_W   head op write data
// - mem_rdata  in   DATA_W   VRAM read data
// - pal_we     out  1        palette write strobe, address = vaddr_o[4:0]
// - pal_wdata  out  DATA_W   palette write data
// - pal_rdata  in   DATA_W   palette data at vaddr_o[4:0], combinational from parent
// - q_ovf      out  1        sticky: op dropped on full queue; cleared only by rst
// - busy       out  1        queue non-empty or read in flight
// BEHAVIOUR
// - Reset: vaddr = 0, t_hi = 0, w = 0, readbuf = 0, reg_rdata = 0, queue empty, FSM IDLE.
//   All outputs 0. Reset mid-operation flushes the queue and drops any in-flight read.
// - ADDR write, w=0: t_hi <= wdata[5:0]; w <= 1.
// - ADDR write, w=1: vaddr <= {t_hi, wdata}; w <= 0.
// - SCROLL write: flips w only. w_clr has priority over any same-cycle flip.
// - DATA write, vaddr[13:8]==PAL_HI: pal_we pulses next cycle, bypasses the queue.
// - DATA write, other addresses: enqueue {we=1, vaddr, wdata}.
// - DATA read, non-palette: reg_rdata <= readbuf; enqueue {we=0, vaddr}.
// - DATA read, palette: reg_rdata <= pal_rdata; enqueue read of vaddr & 'h2FFF
//   (buffer gets the underlying nametable byte).
// - Every DATA access: vaddr <= vaddr + (inc32 ? 32 : 1), wrapping modulo 2^ADDR_W.
// - Queue full on enqueue: op dropped, q_ovf <= 1. vaddr still increments.
// - Enqueue and dequeue in the same cycle: count unchanged, FIFO order preserved.
// - DATA read while an earlier read is still queued: returns the stale readbuf (NES-accurate).
// - FSM IDLE: mem_req = queue non-empty; on mem_gnt, pop head.
//   Write pops go to IDLE. Read pops go to RD_WAIT.
// - FSM RD_WAIT: count RD_LAT cycles; readbuf <= mem_rdata on the last cycle; -> IDLE.
//   mem_req = 0 while in RD_WAIT.
// - mem_* outputs are driven from the queue head, stable while mem_req && !mem_gnt.
// - busy = (count != 0) || (state == RD_WAIT).
// STRUCTURE
// - ppudefs.vh: PPUSCROLL/PPUADDR/PPUDATA indices, PAL_HI, FSM state enum, op struct {we, addr, data}.
// - One sub-module: ppu_op_fifo (sync FIFO, DEPTH/WIDTH params, full/empty/count).
// TESTING
// - Write ADDR $21,$08; write DATA $AA, $BB, gnt held 1 -> mem writes $2108=$AA,
//   $2109=$BB in order; vaddr_o = $210A.
// - inc32=1; write ADDR $20,$00; write DATA x3 -> mem addrs $2000, $2020, $2040.
// - Preload VRAM $2400=$5A; ADDR $24,$00; DATA read x2 -> first returns old readbuf,
//   second returns $5A.
// - ADDR $3F,$01; DATA write $16 -> pal_we=1, pal_wdata=$16, mem_req=0;
//   a read of $3F01 returns pal_rdata, readbuf <= VRAM[$2F01].
// - gnt held 0; 5 DATA writes, Q_DEPTH=4 -> q_ovf=1, exactly 4 ops drain once gnt=1.
// - Assert rst with 3 ops queued and a read in flight -> mem_req=0, busy=0,
//   w_o=0, vaddr_o=0 the next cycle.

Source files
------------

// File: rtl/ppu_vram_port_pkg.sv
// Shared definitions for the PPU CPU-side VRAM port: register indices,
// palette window, nametable mirror mask and the port FSM states.
package ppu_vram_port_pkg;

    localparam logic [2:0] REG_SCROLL = 3'd5;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;

    // addr[13:8] value that selects palette RAM
    localparam logic [5:0] PAL_HI_DEF = 6'h3F;

    // A palette read refills the read buffer from the nametable byte underneath
    localparam int NT_MASK = 'h2FFF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/ppu_vram_port_if.sv
// Posted-op bus between the CPU VRAM port (master) and the VRAM/CHR arbiter (slave).
interface ppu_vram_port_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata
    );
endinterface

// File: rtl/ppu_vram_port_op_fifo.sv
// Small synchronous FIFO holding posted VRAM ops; head is visible on dout.
module ppu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA engine: address and w toggle, PPUDATA read buffer,
// posted op queue drained in render-idle slots, palette writes bypass the queue.
module ppu_vram_port
    import ppu_vram_port_pkg::*;
#(
    parameter int         ADDR_W  = 14,
    parameter int         DATA_W  = 8,
    parameter int         Q_DEPTH = 4,
    parameter int         RD_LAT  = 1,
    parameter logic [5:0] PAL_HI  = PAL_HI_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we,
    input  logic              reg_re,
    input  logic [2:0]        reg_sel,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    input  logic              inc32,
    input  logic              w_clr,
    output logic              w_o,
    output logic [ADDR_W-1:0] vaddr_o,
    ppu_vram_port_if.master   mem,
    output logic              pal_we,
    output logic [DATA_W-1:0] pal_wdata,
    input  logic [DATA_W-1:0] pal_rdata,
    output logic              q_ovf,
    output logic              busy
);
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    localparam int OP_W  = $bits(op_t);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [ADDR_W-1:0]        vaddr_q, vaddr_d;
    logic [5:0]               t_hi_q, t_hi_d;
    logic                     w_q, w_d;
    logic [DATA_W-1:0]        readbuf_q, reg_rdata_q, pal_wdata_q;
    logic                     pal_we_q, q_ovf_q;
    state_e                   state_q;
    logic [LAT_W-1:0]         lat_q;

    logic                     addr_wr, scroll_wr, data_wr, data_rd, data_acc, is_pal;
    logic                     push, pop, q_full, q_empty, mem_req;
    logic [$clog2(Q_DEPTH):0] q_count;
    op_t                      push_op, head_op;
    logic [OP_W-1:0]          head_bits;

    // Decode CPU strobes and build the op that a DATA access would post
    always_comb begin
        addr_wr   = reg_we && (reg_sel == REG_ADDR);
        scroll_wr = reg_we && (reg_sel == REG_SCROLL);
        data_wr   = reg_we && (reg_sel == REG_DATA);
        data_rd   = reg_re && (reg_sel == REG_DATA) && !data_wr;
        data_acc  = data_wr || data_rd;
        is_pal    = (vaddr_q[ADDR_W-1 -: 6] == PAL_HI);
        push      = data_rd || (data_wr && !is_pal);
        push_op.we   = data_wr;
        push_op.addr = (data_rd && is_pal) ? (vaddr_q & ADDR_W'(NT_MASK)) : vaddr_q;
        push_op.data = reg_wdata;
    end

    // Next-state for the CPU address, high-byte latch and write toggle
    always_comb begin
        vaddr_d = vaddr_q;
        t_hi_d  = t_hi_q;
        w_d     = w_q;
        if (addr_wr) begin
            if (!w_q) t_hi_d  = reg_wdata[5:0];
            else      vaddr_d = ADDR_W'({t_hi_q, reg_wdata});
        end
        if (data_acc) vaddr_d = vaddr_q + (inc32 ? ADDR_W'(32) : ADDR_W'(1));
        if (w_clr)                       w_d = 1'b0;
        else if (addr_wr || scroll_wr)   w_d = ~w_q;
    end

    ppu_op_fifo #(
        .DEPTH (Q_DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_op),
        .pop   (pop),
        .dout  (head_bits),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign head_op = op_t'(head_bits);
    assign mem_req = (state_q == ST_IDLE) && !q_empty;
    assign pop     = mem_req && mem.mem_gnt;

    // CPU-visible registers: address, toggle, read result, palette strobe, overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            vaddr_q     <= '0;
            t_hi_q      <= '0;
            w_q         <= 1'b0;
            reg_rdata_q <= '0;
            pal_we_q    <= 1'b0;
            pal_wdata_q <= '0;
            q_ovf_q     <= 1'b0;
        end else begin
            vaddr_q  <= vaddr_d;
            t_hi_q   <= t_hi_d;
            w_q      <= w_d;
            pal_we_q <= data_wr && is_pal;
            if (data_wr && is_pal) pal_wdata_q <= reg_wdata;
            if (data_rd)           reg_rdata_q <= is_pal ? pal_rdata : readbuf_q;
            if (push && q_full)    q_ovf_q     <= 1'b1;
        end
    end

    // Drain FSM: pops the head in IDLE, waits RD_LAT cycles on reads to refill the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            readbuf_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop && !head_op.we) begin
                        state_q <= ST_RD_WAIT;
                        lat_q   <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_q == LAT_W'(RD_LAT - 1)) begin
                        readbuf_q <= mem.mem_rdata;
                        state_q   <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_req && head_op.we;
    assign mem.mem_addr  = mem_req ? head_op.addr : '0;
    assign mem.mem_wdata = mem_req ? head_op.data : '0;

    assign reg_rdata = reg_rdata_q;
    assign w_o       = w_q;
    assign vaddr_o   = vaddr_q;
    assign pal_we    = pal_we_q;
    assign pal_wdata = pal_wdata_q;
    assign q_ovf     = q_ovf_q;
    assign busy      = (q_count != '0) || (state_q == ST_RD_WAIT);
endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: directed scenarios followed by random CPU/arbiter
// traffic, checked against a transaction-level model (op queue + VRAM array).
`timescale 1ns/1ps
module tb_ppu_vram_port;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int Q_DEPTH = 4;
    localparam int RD_LAT  = 1;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } op_s;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we, reg_re, inc32, w_clr;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_wdata, reg_rdata, pal_wdata, pal_rdata;
    logic        w_o, pal_we, q_ovf, busy;
    logic [13:0] vaddr_o;

    ppu_vram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    ppu_vram_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .Q_DEPTH(Q_DEPTH), .RD_LAT(RD_LAT), .PAL_HI(6'h3F)
    ) dut (
        .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re), .reg_sel(reg_sel),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .inc32(inc32), .w_clr(w_clr),
        .w_o(w_o), .vaddr_o(vaddr_o), .mem(mif), .pal_we(pal_we), .pal_wdata(pal_wdata),
        .pal_rdata(pal_rdata), .q_ovf(q_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [7:0]  vram [16384];
    logic [7:0]  pal_mem [32];
    logic [13:0] m_vaddr = '0;
    logic [5:0]  m_thi = '0;
    logic        m_w = 1'b0, m_ovf = 1'b0, m_pal_we = 1'b0;
    logic [7:0]  m_readbuf = '0, m_rdata = '0, m_pal_wdata = '0;
    int          m_rd_wait = 0;
    logic [13:0] rd_addr = '0;
    op_s         mq[$];
    op_s         acc_log[$];

    int checks = 0;
    int passes = 0;

    assign mif.mem_rdata = vram[rd_addr];
    assign pal_rdata     = pal_mem[m_vaddr[4:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: snapshot inputs/bus before the edge, advance the model after it, compare.
    task automatic tick();
        logic        s_rst, s_we, s_re, s_inc, s_wclr, s_req, s_gnt, s_mwe, was_pal;
        logic [2:0]  s_sel;
        logic [7:0]  s_wd, s_mwd, old_rb;
        logic [13:0] s_maddr;
        int          qsz;
        op_s         o;
        @(negedge clk);
        s_rst = rst; s_we = reg_we; s_re = reg_re; s_sel = reg_sel; s_wd = reg_wdata;
        s_inc = inc32; s_wclr = w_clr;
        s_req = mif.mem_req; s_gnt = mif.mem_gnt; s_mwe = mif.mem_we;
        s_maddr = mif.mem_addr; s_mwd = mif.mem_wdata;
        chk("mem_req", s_req, (mq.size() != 0) && (m_rd_wait == 0));
        @(posedge clk);
        #1;
        if (s_rst) begin
            mq.delete();
            m_rd_wait = 0; m_vaddr = '0; m_thi = '0; m_w = 1'b0; m_readbuf = '0;
            m_rdata = '0; m_pal_we = 1'b0; m_pal_wdata = '0; m_ovf = 1'b0;
        end else begin
            qsz = mq.size();
            old_rb = m_readbuf;
            if (m_rd_wait > 0) begin
                m_rd_wait--;
                if (m_rd_wait == 0) m_readbuf = vram[rd_addr];
            end
            if (s_req && s_gnt) begin
                if (mq.size() == 0) chk("pop_empty", 1, 0);
                else begin
                    o = mq.pop_front();
                    chk("mem_we", s_mwe, o.we);
                    chk("mem_addr", s_maddr, o.addr);
                    acc_log.push_back('{we: s_mwe, addr: s_maddr, data: s_mwd});
                    if (o.we) begin
                        chk("mem_wdata", s_mwd, o.data);
                        vram[o.addr] = o.data;
                    end else begin
                        rd_addr   = o.addr;
                        m_rd_wait = RD_LAT;
                    end
                end
            end
            was_pal  = (m_vaddr[13:8] == 6'h3F);
            m_pal_we = 1'b0;
            if (s_we && s_sel == 3'd6) begin
                if (!m_w) m_thi = s_wd[5:0];
                else      m_vaddr = {m_thi, s_wd};
            end
            if ((s_we || s_re) && s_sel == 3'd7) begin
                if (s_we && was_pal) begin
                    m_pal_we = 1'b1;
                    m_pal_wdata = s_wd;
                end else begin
                    o.we   = s_we;
                    o.addr = (!s_we && was_pal) ? (m_vaddr & 14'h2FFF) : m_vaddr;
                    o.data = s_we ? s_wd : 8'h00;
                    if (qsz >= Q_DEPTH) m_ovf = 1'b1;
                    else                mq.push_back(o);
                end
                if (s_re && !s_we) m_rdata = was_pal ? pal_mem[m_vaddr[4:0]] : old_rb;
                m_vaddr = m_vaddr + (s_inc ? 14'd32 : 14'd1);
            end
            if (s_wclr) m_w = 1'b0;
            else if (s_we && (s_sel == 3'd5 || s_sel == 3'd6)) m_w = ~m_w;
        end
        chk("vaddr_o", vaddr_o, m_vaddr);
        chk("w_o", w_o, m_w);
        chk("q_ovf", q_ovf, m_ovf);
        chk("busy", busy, (mq.size() != 0) || (m_rd_wait != 0));
        chk("reg_rdata", reg_rdata, m_rdata);
        chk("pal_we", pal_we, m_pal_we);
        if (m_pal_we) chk("pal_wdata", pal_wdata, m_pal_wdata);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        reg_we = 1'b1; reg_sel = sel; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel);
        reg_re = 1'b1; reg_sel = sel;
        tick();
        reg_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int          n0, k;
        logic [7:0]  rb_before, d;
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) pal_mem[i] = 8'($urandom);
        rst = 1'b1; reg_we = 1'b0; reg_re = 1'b0; reg_sel = 3'd0; reg_wdata = '0;
        inc32 = 1'b0; w_clr = 1'b0; mif.mem_gnt = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        rst = 1'b0;
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_mem_addr", mif.mem_addr, 0);
        chk("rst_pal_wdata", pal_wdata, 0);
        chk("rst_reg_rdata", reg_rdata, 0);
        chk("rst_vaddr", vaddr_o, 0);

        // Two writes through the queue with grant held
        mif.mem_gnt = 1'b1;
        wr(3'd6, 8'h21); wr(3'd6, 8'h08);
        n0 = acc_log.size();
        wr(3'd7, 8'hAA); wr(3'd7, 8'hBB);
        idle(3);
        chk("t1_vaddr", vaddr_o, 14'h210A);
        chk("t1_nops", acc_log.size() - n0, 2);
        chk("t1_addr0", acc_log[n0].addr, 14'h2108);
        chk("t1_data0", acc_log[n0].data, 8'hAA);
        chk("t1_addr1", acc_log[n0+1].addr, 14'h2109);
        chk("t1_data1", acc_log[n0+1].data, 8'hBB);

        // Step of 32
        inc32 = 1'b1;
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        n0 = acc_log.size();
        repeat (3) wr(3'd7, 8'($urandom));
        idle(3);
        inc32 = 1'b0;
        chk("t2_addr0", acc_log[n0].addr, 14'h2000);
        chk("t2_addr1", acc_log[n0+1].addr, 14'h2020);
        chk("t2_addr2", acc_log[n0+2].addr, 14'h2040);

        // Buffered read: first returns old buffer, second the preloaded byte
        vram[14'h2400] = 8'h5A;
        rb_before = m_readbuf;
        wr(3'd6, 8'h24); wr(3'd6, 8'h00);
        rd(3'd7);
        chk("t3_rd1", reg_rdata, rb_before);
        idle(4);
        rd(3'd7);
        chk("t3_rd2", reg_rdata, 8'h5A);
        idle(4);

        // Palette write bypasses the queue; palette read refills from nametable
        wr(3'd6, 8'h3F); wr(3'd6, 8'h01);
        wr(3'd7, 8'h16);
        chk("t4_pal_we", pal_we, 1);
        chk("t4_pal_wdata", pal_wdata, 8'h16);
        chk("t4_mem_req", mif.mem_req, 0);
        vram[14'h2F01] = 8'h77;
        pal_mem[1] = 8'h2C;
        wr(3'd6, 8'h3F); wr(3'd6, 8'h01);
        rd(3'd7);
        chk("t4_pal_rd", reg_rdata, 8'h2C);
        idle(4);
        wr(3'd6, 8'h20); wr(3'd6, 8'h00);
        rd(3'd7);
        chk("t4_nt_buf", reg_rdata, 8'h77);
        idle(4);

        // Overflow: five writes into a four-deep queue with no grant
        mif.mem_gnt = 1'b0;
        wr(3'd6, 8'h21); wr(3'd6, 8'h00);
        for (int i = 0; i < 5; i++) wr(3'd7, 8'(i + 1));
        chk("t5_ovf", q_ovf, 1);
        n0 = acc_log.size();
        mif.mem_gnt = 1'b1;
        idle(8);
        chk("t5_drained", acc_log.size() - n0, 4);
        chk("t5_ovf_sticky", q_ovf, 1);

        // Reset with three ops queued and a read in flight
        mif.mem_gnt = 1'b0;
        wr(3'd6, 8'h22); wr(3'd6, 8'h00);
        rd(3'd7);
        wr(3'd7, 8'h01); wr(3'd7, 8'h02); wr(3'd7, 8'h03);
        wr(3'd6, 8'h23);
        mif.mem_gnt = 1'b1;
        tick();
        mif.mem_gnt = 1'b0;
        chk("t6_busy_pre", busy, 1);
        chk("t6_w_pre", w_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_mem_req", mif.mem_req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_w", w_o, 0);
        chk("t6_vaddr", vaddr_o, 0);
        chk("t6_ovf", q_ovf, 0);
        idle(2);

        // Random CPU and arbiter traffic
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            d = 8'($urandom);
            reg_we = 1'b0; reg_re = 1'b0; reg_sel = 3'd0;
            case (k)
                3: begin
                    reg_we = 1'b1; reg_sel = 3'd6;
                    if ($urandom_range(0, 2) == 0) d[5:0] = 6'h3F;
                end
                4: begin reg_we = 1'b1; reg_sel = 3'd5; end
                5, 6: begin reg_we = 1'b1; reg_sel = 3'd7; end
                7, 8: begin reg_re = 1'b1; reg_sel = 3'd7; end
                9: begin reg_re = 1'b1; reg_sel = 3'd2; end
                default: ;
            endcase
            reg_wdata = d;
            inc32 = ($urandom_range(0, 3) == 0);
            w_clr = ($urandom_range(0, 7) == 0);
            mif.mem_gnt = ($urandom_range(0, 2) != 0);
            tick();
        end
        reg_we = 1'b0; reg_re = 1'b0; w_clr = 1'b0; inc32 = 1'b0;
        mif.mem_gnt = 1'b1;
        idle(10);
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
